// File: rtl/result_writer.sv
// Requantizes multi_controller results to 8-bit pixels and writes them sequentially into the output RAM.
// A small FIFO with empty-FIFO bypass absorbs RAM stalls; busy, all_done and overflow report progress.
module result_writer #(
  parameter int DATA_W     = 24,
  parameter int OUT_W      = 8,
  parameter int ADDR_W     = 10,
  parameter int SHIFT      = 8,
  parameter int NUM_OUT    = 900,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] s_out_addr,
  input  logic [DATA_W-1:0] calc_data,
  input  logic              done,
  input  logic              ram_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_ena,
  output logic              out_wea,
  output logic [OUT_W-1:0]  out_data,
  output logic              busy,
  output logic              all_done,
  output logic              overflow,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(NUM_OUT + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [CNT_W-1:0]  NUM_C   = CNT_W'(NUM_OUT);
  localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(NUM_OUT - 1);
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] SAT_MAX = {{(DATA_W - OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic [1:0]        state;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  push_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [PTR_W-1:0]  rptr;
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W:0]    count;
  logic [OUT_W-1:0]  mem [FIFO_DEPTH];

  logic [DATA_W-1:0] shifted;
  logic [OUT_W-1:0]  requant;
  logic [OUT_W-1:0]  head;
  logic [ADDR_W-1:0] wr_off;
  logic              running;
  logic              empty;
  logic              full;
  logic              push_ok;
  logic              pop;
  logic              drop;

  assign dbg_state = state;
  assign running   = (state == S_RUN);
  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign wr_off    = ADDR_W'(wr_cnt);

  // Negative results clamp to zero; positive ones are scaled down and saturated.
  assign shifted = calc_data >> SHIFT;
  always_comb begin
    requant = '0;
    if (!calc_data[DATA_W-1]) begin
      if (shifted > SAT_MAX) requant = '1;
      else                   requant = shifted[OUT_W-1:0];
    end
  end

  // A full FIFO can still accept when ram_ready guarantees a pop this cycle.
  assign push_ok = running && done && (push_cnt < NUM_C) && (!full || ram_ready);
  assign drop    = running && done && !push_ok;
  assign pop     = running && ram_ready && (!empty || push_ok);
  assign head    = empty ? requant : mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= requant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      base     <= '0;
      push_cnt <= '0;
      wr_cnt   <= '0;
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      out_addr <= '0;
      out_ena  <= 1'b0;
      out_wea  <= 1'b0;
      out_data <= '0;
      busy     <= 1'b0;
      all_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      out_ena  <= 1'b0;
      out_wea  <= 1'b0;
      all_done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            base     <= s_out_addr;
            push_cnt <= '0;
            wr_cnt   <= '0;
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_RUN: begin
          if (pop && (wr_cnt == LAST_C)) state <= S_FIN;
        end
        S_FIN: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          all_done <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase

      if (push_ok) begin
        wptr     <= wptr + 1'b1;
        push_cnt <= push_cnt + 1'b1;
      end

      if (pop) begin
        rptr     <= rptr + 1'b1;
        wr_cnt   <= wr_cnt + 1'b1;
        out_ena  <= 1'b1;
        out_wea  <= 1'b1;
        out_data <= head;
        out_addr <= base + wr_off;
      end

      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_result_writer.sv
// Bench for result_writer: two instances (4 and 900 results per layer), a queue-based reference
// model predicting every RAM write, and a negedge monitor that checks writes against it.
module tb_result_writer;

  localparam int DATA_W = 24;
  localparam int OUT_W  = 8;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;
  localparam int EW     = 32 + ADDR_W + OUT_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              done = 1'b0;
  logic              ram_ready = 1'b0;
  logic [ADDR_W-1:0] s_out_addr = '0;
  logic [DATA_W-1:0] calc_data = '0;
  logic              sel = 1'b0;

  logic [ADDR_W-1:0] a_addr, b_addr, o_addr;
  logic [OUT_W-1:0]  a_data, b_data, o_data;
  logic              a_ena, a_wea, a_busy, a_all, a_ovf;
  logic              b_ena, b_wea, b_busy, b_all, b_ovf;
  logic              o_ena, o_wea, o_busy, o_all, o_ovf;
  logic [1:0]        a_st, b_st, o_st;

  result_writer #(.NUM_OUT(4)) dut_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .s_out_addr(s_out_addr),
    .calc_data(calc_data), .done(done & ~sel), .ram_ready(ram_ready),
    .out_addr(a_addr), .out_ena(a_ena), .out_wea(a_wea), .out_data(a_data),
    .busy(a_busy), .all_done(a_all), .overflow(a_ovf), .dbg_state(a_st)
  );

  result_writer #(.NUM_OUT(900)) dut_b (
    .clk(clk), .rst(rst), .start(start & sel), .s_out_addr(s_out_addr),
    .calc_data(calc_data), .done(done & sel), .ram_ready(ram_ready),
    .out_addr(b_addr), .out_ena(b_ena), .out_wea(b_wea), .out_data(b_data),
    .busy(b_busy), .all_done(b_all), .overflow(b_ovf), .dbg_state(b_st)
  );

  assign o_addr = sel ? b_addr : a_addr;
  assign o_data = sel ? b_data : a_data;
  assign o_ena  = sel ? b_ena  : a_ena;
  assign o_wea  = sel ? b_wea  : a_wea;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_all  = sel ? b_all  : a_all;
  assign o_ovf  = sel ? b_ovf  : a_ovf;
  assign o_st   = sel ? b_st   : a_st;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: layer phase, accepted-result queue, and predicted writes.
  int                m_mode = 0;  // 0 idle, 1 running, 2 finishing
  logic [ADDR_W-1:0] m_base = '0;
  int                m_pushed = 0;
  int                m_wr = 0;
  bit                m_ovf = 1'b0;
  bit                e_busy = 1'b0;
  bit                e_done = 1'b0;
  logic [OUT_W-1:0]  m_fifo[$];
  logic [EW-1:0]     exp_q[$];

  function automatic logic [OUT_W-1:0] requant(input logic [DATA_W-1:0] d);
    int v;
    if (d[DATA_W-1]) return '0;
    v = int'(d) / 256;
    return (v > 255) ? 8'd255 : OUT_W'(v);
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    case ($urandom_range(0, 2))
      0:       return DATA_W'($urandom) & 24'h00FFFF;
      1:       return DATA_W'($urandom);
      default: return DATA_W'($urandom) & 24'h7FFFFF;
    endcase
  endfunction

  task automatic step(input bit r, input bit st, input logic [ADDR_W-1:0] a,
                      input bit dn, input logic [DATA_W-1:0] d, input bit rdy);
    bit                acc;
    int                n;
    logic [OUT_W-1:0]  v;
    logic [ADDR_W-1:0] ad;
    logic [31:0]       cn;
    rst = r; start = st; s_out_addr = a; done = dn; calc_data = d; ram_ready = rdy;
    n = sel ? 900 : 4;
    if (r) begin
      m_mode = 0; m_ovf = 0; m_pushed = 0; m_wr = 0; m_fifo.delete();
      e_busy = 0; e_done = 0;
    end else begin
      e_done = (m_mode == 2);
      case (m_mode)
        0: if (st) begin
          m_mode = 1; m_base = a; m_pushed = 0; m_wr = 0; m_ovf = 0;
        end
        1: begin
          acc = dn && (m_pushed < n) && ((m_fifo.size() < DEPTH) || rdy);
          if (dn && !acc) m_ovf = 1;
          if (acc) begin
            m_fifo.push_back(requant(d));
            m_pushed++;
          end
          if (rdy && m_fifo.size() > 0) begin
            v  = m_fifo.pop_front();
            ad = m_base + ADDR_W'(m_wr);
            cn = 32'(cyc + 1);
            exp_q.push_back({cn, ad, v});
            m_wr++;
            if (m_wr == n) m_mode = 2;
          end
        end
        default: m_mode = 0;
      endcase
      e_busy = (m_mode != 0);
    end
    @(posedge clk);
    #1;
    check("busy", o_busy, e_busy);
    check("all_done", o_all, e_done);
    check("overflow", o_ovf, m_ovf);
    check("wea_matches_ena", o_wea, o_ena);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, 1);
  endtask

  task automatic layer4(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d0,
                        input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                        input logic [DATA_W-1:0] d3);
    step(0, 1, a, 0, '0, 1);
    step(0, 0, '0, 1, d0, 1);
    step(0, 0, '0, 1, d1, 1);
    step(0, 0, '0, 1, d2, 1);
    step(0, 0, '0, 1, d3, 1);
    idle(4);
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    bit            have;
    while (exp_q.size() > 0 && exp_q[0][EW-1 -: 32] < 32'(cyc)) begin
      e = exp_q.pop_front();
      check("missed_write_cycle", 32'(cyc), e[EW-1 -: 32]);
    end
    if (o_ena) begin
      have = (exp_q.size() > 0);
      check("write_expected", have, 1);
      if (have) begin
        e = exp_q.pop_front();
        check("write_cycle", 32'(cyc), e[EW-1 -: 32]);
        check("write_addr", o_addr, e[OUT_W +: ADDR_W]);
        check("write_data", o_data, e[OUT_W-1:0]);
      end
    end
  end

  initial begin
    // Reset state
    step(1, 0, '0, 0, '0, 0);
    step(1, 0, '0, 0, '0, 0);
    check("reset_ena", o_ena, 0);
    check("reset_addr", o_addr, 0);
    check("reset_data", o_data, 0);
    check("reset_state", o_st, 0);

    // Basic requantization: 0x01, 0xFF, saturated 0xFF, ReLU 0x00
    layer4(10'h000, 24'h000100, 24'h00FF00, 24'h123456, 24'hFFFF00);

    // Stall: five back-to-back results while the RAM is unavailable
    step(0, 1, 10'h080, 0, '0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, '0, 1, rnd_data(), 0);
    step(0, 0, '0, 0, '0, 0);
    check("stall_overflow", o_ovf, 1);
    idle(6);

    // Address wrap
    layer4(10'h3FE, rnd_data(), rnd_data(), rnd_data(), rnd_data());

    // Reset after two writes, then restart at 0x010
    step(0, 1, 10'h000, 0, '0, 1);
    step(0, 0, '0, 1, 24'h002300, 1);
    step(0, 0, '0, 1, 24'h004500, 1);
    step(1, 0, '0, 1, 24'h006700, 1);
    check("midreset_ena", o_ena, 0);
    check("midreset_addr", o_addr, 0);
    check("midreset_data", o_data, 0);
    idle(3);
    layer4(10'h010, rnd_data(), rnd_data(), rnd_data(), rnd_data());
    check("restart_overflow", o_ovf, 0);

    // start while busy and done while idle are ignored
    step(0, 1, 10'h020, 0, '0, 1);
    step(0, 0, '0, 1, rnd_data(), 1);
    step(0, 0, '0, 1, rnd_data(), 1);
    step(0, 1, 10'h100, 1, rnd_data(), 1);
    step(0, 0, '0, 1, rnd_data(), 1);
    idle(4);
    step(0, 0, '0, 1, rnd_data(), 1);
    idle(2);
    check("idle_done_overflow", o_ovf, 0);

    // Randomized layers
    for (int l = 0; l < 15; l++) begin
      step(0, 1, ADDR_W'($urandom), 0, '0, 1);
      for (int i = 0; i < 80 && m_mode != 0; i++)
        step(0, ($urandom_range(0, 9) == 0), ADDR_W'($urandom), ($urandom_range(0, 2) != 0),
             rnd_data(), ($urandom_range(0, 3) != 0));
      idle(2);
    end

    // Full 900-result layer, one result per cycle, then an extra result
    sel = 1'b1;
    idle(2);
    step(0, 1, ADDR_W'($urandom), 0, '0, 1);
    for (int i = 0; i < 899; i++) step(0, 0, '0, 1, rnd_data(), 1);
    step(0, 0, '0, 1, rnd_data(), 0);
    step(0, 0, '0, 1, rnd_data(), 1);
    idle(4);
    check("extra_result_overflow", o_ovf, 1);

    idle(3);
    check("exp_q_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
